// File: rtl/down_clocking.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// down_clocking
//   Divides clock_in by an integer DIVISOR and produces a 50% duty clock_out.
//   Even divisors use one rising-edge flop. Odd divisors OR a rising-edge flop
//   with a copy of it taken half a cycle later on the falling edge. That adds
//   the extra half input period of high time that an odd ratio needs.
//
// Parameters
//   DIVISOR   : input-to-output frequency ratio, 2..65535
//   CNT_WIDTH : counter width, derived from DIVISOR (leave at default)
//
// Ports
//   clock_in  : source clock
//   rst       : asynchronous reset, active low (0 = in reset)
//   clock_out : divided clock, driven only by registers
// -----------------------------------------------------------------------------
module down_clocking #(
  parameter int DIVISOR   = 4,
  parameter int CNT_WIDTH = $clog2(DIVISOR)
) (
  input  logic clock_in,
  input  logic rst,
  output logic clock_out
);

  if (DIVISOR < 2 || DIVISOR > 65535) begin : g_bad_divisor
    $error("down_clocking: DIVISOR=%0d outside legal range 2..65535", DIVISOR);
  end

  // For even DIVISOR, (DIVISOR+1)/2 truncates to DIVISOR/2. One threshold
  // therefore covers both cases. The high window runs from the threshold up to
  // DIVISOR-1 of the post-edge count.
  localparam logic [CNT_WIDTH-1:0] LAST      = CNT_WIDTH'(DIVISOR - 1);
  localparam logic [CNT_WIDTH-1:0] HIGH_FROM = CNT_WIDTH'((DIVISOR + 1) / 2);

  logic [CNT_WIDTH-1:0] c;
  logic [CNT_WIDTH-1:0] c_next;
  logic                 high_next;
  logic                 q_pos;

  always_comb begin
    c_next    = (c == LAST) ? '0 : c + CNT_WIDTH'(1);
    high_next = (c_next >= HIGH_FROM);
  end

  // The output phase is decoded from the next count, not the current one. This
  // lets q_pos change on the same edge as c, and the first rise lands on edge
  // HIGH_FROM after reset release.
  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      c     <= '0;
      q_pos <= 1'b0;
    end else begin
      c     <= c_next;
      q_pos <= high_next;
    end
  end

  if (DIVISOR % 2 == 0) begin : g_even
    assign clock_out = q_pos;
  end else begin : g_odd
    // q_neg trails q_pos by half an input period. The OR of the two stretches
    // the high phase by that half period. Both inputs to the OR are flops, so
    // clock_in never reaches clock_out combinationally.
    logic q_neg;
    always_ff @(negedge clock_in or negedge rst) begin
      if (!rst) q_neg <= 1'b0;
      else      q_neg <= q_pos;
    end
    assign clock_out = q_pos | q_neg;
  end

endmodule

// File: tb/tb_down_clocking.sv
`timescale 1ns/1ps
// Bench for down_clocking. It runs four instances (DIVISOR = 2, 3, 4, 5) from
// one 10 ns clock and one shared reset. outs bit order is {div5, div4, div3, div2}.
module tb_down_clocking;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic o2, o3, o4, o5;
  logic [3:0] outs;
  assign outs = {o5, o4, o3, o2};

  down_clocking #(.DIVISOR(2)) u_d2 (.clock_in(clk), .rst(rst), .clock_out(o2));
  down_clocking #(.DIVISOR(3)) u_d3 (.clock_in(clk), .rst(rst), .clock_out(o3));
  down_clocking #(.DIVISOR(4)) u_d4 (.clock_in(clk), .rst(rst), .clock_out(o4));
  down_clocking #(.DIVISOR(5)) u_d5 (.clock_in(clk), .rst(rst), .clock_out(o5));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // h counts half input periods from reset release. h = 2k is just after
  // rising edge k, and h = 2k+1 is just after the falling edge that follows it.
  typedef struct {
    int         h;
    logic [3:0] exp;
  } vec_t;

  vec_t       tbl [24];
  logic [3:0] sb [$];

  // Monitors clock_out of the divide-by-5 instance during the long run.
  logic mon_en = 1'b0;
  int   rises = 0;
  int   bad_high = 0;
  time  t_rise = 0;

  always @(posedge o5) if (mon_en) begin rises++; t_rise = $time; end
  always @(negedge o5) if (mon_en && rises > 0 && ($time - t_rise) != 25) bad_high++;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference waveform, taken from the timing of a 50% duty divided clock.
  // Even d: high for the second half of each 2d half-period frame.
  // Odd d:  first rise on edge (d+1)/2, high for d half periods.
  function automatic logic model(input int d, input int h);
    int p;
    p = h % (2 * d);
    if (d % 2 == 0) return (p >= d);
    return (p >= d + 1) || (p == 0 && h > 0);
  endfunction

  task automatic apply_table(input string tag);
    logic [3:0] e;
    for (int i = 0; i < 24; i++) begin
      if (i == 0) @(posedge clk); else @(clk);
      sb.push_back(tbl[i].exp);
      #1;
      e = sb.pop_front();
      for (int d = 0; d < 4; d++)
        check($sformatf("%s h=%0d div%0d", tag, tbl[i].h, d + 2), outs[d], e[d]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] p2, p3, p4, p5;
    logic [3:0]  e;
    // Expected clock_out for h = 2..25, leftmost bit first.
    p2 = 24'b1100_1100_1100_1100_1100_1100;
    p3 = 24'b0011_1000_1110_0011_1000_1110;
    p4 = 24'b0011_1100_0011_1100_0011_1100;
    p5 = 24'b0000_1111_1000_0011_1110_0000;
    for (int i = 0; i < 24; i++) begin
      tbl[i].h   = i + 2;
      tbl[i].exp = {p5[23-i], p4[23-i], p3[23-i], p2[23-i]};
    end

    // Reset held for 3 input periods: all outputs 0 and never X.
    for (int i = 0; i < 6; i++) begin
      @(clk);
      sb.push_back(4'b0000);
      #1;
      e = sb.pop_front();
      for (int d = 0; d < 4; d++)
        check($sformatf("reset s%0d div%0d", i, d + 2), outs[d], e[d]);
    end
    #1 rst = 1'b1;   // t = 32, away from both clock edges
    apply_table("run1");

    // Mid-period reset while the divide-by-4 output is high (h = 28).
    @(posedge clk);
    @(posedge clk);
    #1;
    check("div4 high before reset", o4, model(4, 28));
    rst = 1'b0;
    #1;
    for (int d = 0; d < 4; d++)
      check($sformatf("async reset div%0d", d + 2), outs[d], 1'b0);
    #2 rst = 1'b1;   // 3 ns pulse, released between clock edges
    apply_table("run2");

    // Long divide-by-5 run: 1000 input cycles after a fresh reset.
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++)
      check($sformatf("reset with clock div%0d", d + 2), outs[d], 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    mon_en = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      #1 check($sformatf("long div5 h=%0d", 2 * k), o5, model(5, 2 * k));
      @(negedge clk);
      #1 check($sformatf("long div5 h=%0d", 2 * k + 1), o5, model(5, 2 * k + 1));
    end
    mon_en = 1'b0;
    check_int("div5 rising edges in 1000 cycles", rises, 200);
    check_int("div5 high phases not 25ns", bad_high, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
